// File: rtl/cam_ctrl_pkg.sv
// Shared types and widths for the camera frame scheduler.
package cam_ctrl_pkg;

  localparam int unsigned CAM_WORD_W  = 32;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned DROP_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RENDER,
    GAP
  } cam_sched_state_t;

endpackage

// File: rtl/cam_frame_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module cam_frame_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = load_val;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - W'(1);
    end
  end

  // expired is registered from the next count so it lines up with cnt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      expired <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/camera_frame_scheduler.sv
// Sequences render frames against camera updates: shadow/active camera
// registers, start handshake, inter-frame gap and render timeout.
module camera_frame_scheduler
  import cam_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W         = CAM_WORD_W,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned FREE_RUN       = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   upd_valid,
  input  logic [WORD_W-1:0]      upd_pos,
  input  logic [WORD_W-1:0]      upd_dir,
  output logic                   start_valid,
  input  logic                   start_ready,
  output logic [WORD_W-1:0]      cam_pos,
  output logic [WORD_W-1:0]      cam_dir,
  input  logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [DROP_CNT_W-1:0]  drop_count,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

  cam_sched_state_t  state;
  cam_sched_state_t  state_nxt;
  logic              pend;
  logic [WORD_W-1:0] shadow_pos;
  logic [WORD_W-1:0] shadow_dir;
  logic              take_c;
  logic              tmr_load_c;
  logic [TMR_W-1:0]  tmr_val_c;
  logic              frame_inc_c;
  logic              to_set_c;
  logic              tmr_expired;

  cam_frame_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timer is loaded with N-1 so the state is left exactly N cycles after entry
  always_comb begin
    state_nxt   = state;
    take_c      = 1'b0;
    tmr_load_c  = 1'b0;
    tmr_val_c   = GAP_LOAD;
    frame_inc_c = 1'b0;
    to_set_c    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (pend || (FREE_RUN != 0))) begin
          state_nxt = ISSUE;
          take_c    = 1'b1;
        end
      end
      ISSUE: begin
        if (start_ready) begin
          state_nxt  = RENDER;
          tmr_load_c = 1'b1;
          tmr_val_c  = TO_LOAD;
        end
      end
      RENDER: begin
        if (frame_done) begin
          state_nxt   = GAP;
          tmr_load_c  = 1'b1;
          frame_inc_c = 1'b1;
        end else if (tmr_expired) begin
          state_nxt  = GAP;
          tmr_load_c = 1'b1;
          to_set_c   = 1'b1;
        end
      end
      GAP: begin
        if (tmr_expired) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A same-edge update refills the shadow after the copy, so pend stays set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_valid <= 1'b0;
      busy        <= 1'b0;
      pend        <= 1'b0;
      shadow_pos  <= '0;
      shadow_dir  <= '0;
      cam_pos     <= '0;
      cam_dir     <= '0;
      frame_count <= '0;
      drop_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      start_valid <= (state_nxt == ISSUE);
      busy        <= (state_nxt != IDLE);
      pend        <= upd_valid | (pend & ~take_c);
      if (upd_valid) begin
        shadow_pos <= upd_pos;
        shadow_dir <= upd_dir;
      end
      if (upd_valid && pend && !take_c && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_CNT_W'(1);
      end
      if (take_c) begin
        cam_pos <= shadow_pos;
        cam_dir <= shadow_dir;
      end
      if (frame_inc_c) begin
        frame_count <= frame_count + FRAME_CNT_W'(1);
      end
      if (to_set_c) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_camera_frame_scheduler.sv
// Directed bench for camera_frame_scheduler: vector table plus corner sequences.
module tb_camera_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        upd_valid;
  logic [31:0] upd_pos;
  logic [31:0] upd_dir;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] cam_pos;
  logic [31:0] cam_dir;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [7:0]  drop_count;
  logic        timeout_err;
  logic        busy;

  logic        en2;
  logic        sr2;
  logic        fd2;
  logic        sv2;
  logic [31:0] cam_pos2;
  logic [31:0] cam_dir2;
  logic [15:0] fc2;
  logic [7:0]  dc2;
  logic        te2;
  logic        busy2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  camera_frame_scheduler #(
    .WORD_W(32), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16), .FREE_RUN(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .upd_valid(upd_valid),
    .upd_pos(upd_pos), .upd_dir(upd_dir), .start_valid(start_valid),
    .start_ready(start_ready), .cam_pos(cam_pos), .cam_dir(cam_dir),
    .frame_done(frame_done), .frame_count(frame_count), .drop_count(drop_count),
    .timeout_err(timeout_err), .busy(busy)
  );

  camera_frame_scheduler #(
    .WORD_W(32), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16), .FREE_RUN(1)
  ) dut_fr (
    .clk(clk), .reset_n(reset_n), .enable(en2), .upd_valid(1'b0),
    .upd_pos(32'h0), .upd_dir(32'h0), .start_valid(sv2),
    .start_ready(sr2), .cam_pos(cam_pos2), .cam_dir(cam_dir2),
    .frame_done(fd2), .frame_count(fc2), .drop_count(dc2),
    .timeout_err(te2), .busy(busy2)
  );

  typedef struct {
    logic        uv;
    logic [31:0] pos;
    logic [31:0] dir;
    logic        fd;
    logic        sv;
    logic        busy;
    logic [31:0] cpos;
    logic [31:0] cdir;
    logic [15:0] fc;
    logic [7:0]  dc;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mkv(logic uv, logic [31:0] pos, logic [31:0] dir, logic fd,
                               logic sv, logic bz, logic [31:0] cp, logic [31:0] cd,
                               logic [15:0] fc, logic [7:0] dc);
    vec_t v;
    v.uv = uv; v.pos = pos; v.dir = dir; v.fd = fd;
    v.sv = sv; v.busy = bz; v.cpos = cp; v.cdir = cd; v.fc = fc; v.dc = dc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] d);
    upd_valid = 1'b1;
    upd_pos   = p;
    upd_dir   = d;
  endtask

  localparam logic [31:0] P0 = 32'h12345678;
  localparam logic [31:0] D0 = 32'h9ABCDEF0;

  initial begin
    int errs;
    reset_n = 1'b0; enable = 1'b1; upd_valid = 1'b0; upd_pos = '0; upd_dir = '0;
    start_ready = 1'b1; frame_done = 1'b0;
    en2 = 1'b0; sr2 = 1'b1; fd2 = 1'b0;

    // Update -> start latency, drops during RENDER, gap then next frame
    vecs[0] = mkv(1, P0, D0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mkv(0, 0, 0, 0, 1, 1, P0, D0, 0, 0);
    vecs[2] = mkv(0, 0, 0, 0, 0, 1, P0, D0, 0, 0);
    vecs[3] = mkv(1, 32'h1, 32'h11, 0, 0, 1, P0, D0, 0, 0);
    vecs[4] = mkv(1, 32'h2, 32'h22, 0, 0, 1, P0, D0, 0, 1);
    vecs[5] = mkv(1, 32'h3, 32'h33, 0, 0, 1, P0, D0, 0, 2);
    vecs[6] = mkv(0, 0, 0, 1, 0, 1, P0, D0, 1, 2);
    for (int i = 7; i <= 9; i++) vecs[i] = mkv(0, 0, 0, 0, 0, 1, P0, D0, 1, 2);
    vecs[10] = mkv(0, 0, 0, 0, 0, 0, P0, D0, 1, 2);
    vecs[11] = mkv(0, 0, 0, 0, 1, 1, 32'h3, 32'h33, 1, 2);
    vecs[12] = mkv(0, 0, 0, 0, 0, 1, 32'h3, 32'h33, 1, 2);
    vecs[13] = mkv(0, 0, 0, 1, 0, 1, 32'h3, 32'h33, 2, 2);
    for (int i = 14; i <= 16; i++) vecs[i] = mkv(0, 0, 0, 0, 0, 1, 32'h3, 32'h33, 2, 2);
    vecs[17] = mkv(0, 0, 0, 0, 0, 0, 32'h3, 32'h33, 2, 2);

    ticks(2);
    chk("rst_sv", 32'(start_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fc", 32'(frame_count), 0);
    chk("rst_te", 32'(timeout_err), 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      upd_valid = vecs[i].uv; upd_pos = vecs[i].pos; upd_dir = vecs[i].dir;
      frame_done = vecs[i].fd;
      tick();
      chk($sformatf("row%0d_sv", i), 32'(start_valid), 32'(vecs[i].sv));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("row%0d_pos", i), cam_pos, vecs[i].cpos);
      chk($sformatf("row%0d_dir", i), cam_dir, vecs[i].cdir);
      chk($sformatf("row%0d_fc", i), 32'(frame_count), 32'(vecs[i].fc));
      chk($sformatf("row%0d_dc", i), 32'(drop_count), 32'(vecs[i].dc));
    end
    upd_valid = 1'b0; frame_done = 1'b0;

    // Update on the same edge as IDLE->ISSUE
    upd(32'hAAAA0001, 32'hAAAA1001); tick();
    chk("same_pre_sv", 32'(start_valid), 0);
    upd(32'hBBBB0002, 32'hBBBB1002); tick();
    upd_valid = 1'b0;
    chk("same_sv", 32'(start_valid), 1);
    chk("same_old_pos", cam_pos, 32'hAAAA0001);
    chk("same_dc", 32'(drop_count), 2);
    tick();
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    chk("same_fc", 32'(frame_count), 3);
    ticks(4);
    chk("same_gap_sv", 32'(start_valid), 0);
    chk("same_gap_busy", 32'(busy), 0);
    tick();
    chk("same_next_sv", 32'(start_valid), 1);
    chk("same_next_pos", cam_pos, 32'hBBBB0002);
    chk("same_next_dir", cam_dir, 32'hBBBB1002);
    tick();
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    ticks(4);
    chk("same_end_busy", 32'(busy), 0);

    // start_ready held low: ISSUE holds with stable camera, no timeout
    start_ready = 1'b0;
    upd(32'hC0C0C0C0, 32'hC1C1C1C1); tick();
    upd_valid = 1'b0; tick();
    chk("hold_sv", 32'(start_valid), 1);
    chk("hold_pos", cam_pos, 32'hC0C0C0C0);
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      upd_valid = (i == 10); upd_pos = 32'hD0D0D0D0; upd_dir = 32'hD1D1D1D1;
      tick();
      if (!start_valid || cam_pos != 32'hC0C0C0C0 || cam_dir != 32'hC1C1C1C1 || timeout_err)
        errs++;
    end
    upd_valid = 1'b0;
    chk("hold_50_errs", 32'(errs), 0);
    start_ready = 1'b1; tick(); start_ready = 1'b0;
    chk("hold_xfer_sv", 32'(start_valid), 0);
    chk("hold_render_busy", 32'(busy), 1);
    ticks(3);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pos", cam_pos, 0);
    chk("arst_dir", cam_dir, 0);
    chk("arst_fc", 32'(frame_count), 0);
    chk("arst_dc", 32'(drop_count), 0);
    tick();
    reset_n = 1'b1; start_ready = 1'b1;
    ticks(2);
    chk("arst_pend_clear", 32'(busy), 0);

    // Render timeout, then frame_done coincident with the timeout cycle
    upd(32'h51515151, 32'h52525252); tick();
    upd_valid = 1'b0; tick();
    chk("to_sv", 32'(start_valid), 1);
    tick();
    ticks(15);
    chk("to_r15_te", 32'(timeout_err), 0);
    chk("to_r15_busy", 32'(busy), 1);
    tick();
    chk("to_r16_te", 32'(timeout_err), 1);
    chk("to_r16_fc", 32'(frame_count), 0);
    ticks(3);
    chk("to_gap_busy", 32'(busy), 1);
    tick();
    chk("to_idle_busy", 32'(busy), 0);
    upd(32'h61616161, 32'h62626262); tick();
    upd_valid = 1'b0; tick();
    tick();
    ticks(15);
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    chk("coinc_fc", 32'(frame_count), 1);
    chk("coinc_te_sticky", 32'(timeout_err), 1);
    ticks(4);
    chk("coinc_idle", 32'(busy), 0);
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    chk("idle_done_ignored", 32'(frame_count), 1);

    // enable low holds IDLE while updates pile up and saturate the drop counter
    enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      upd(32'(i), 32'(i + 1000)); tick();
    end
    upd_valid = 1'b0;
    chk("sat_dc", 32'(drop_count), 255);
    chk("sat_busy", 32'(busy), 0);
    chk("sat_sv", 32'(start_valid), 0);
    enable = 1'b1; tick();
    chk("sat_start_sv", 32'(start_valid), 1);
    chk("sat_start_pos", cam_pos, 32'd299);

    // Free-running instance
    chk("fr_disabled_busy", 32'(busy2), 0);
    en2 = 1'b1; tick();
    chk("fr_start_sv", 32'(sv2), 1);
    tick();
    chk("fr_render_sv", 32'(sv2), 0);
    chk("fr_render_busy", 32'(busy2), 1);
    fd2 = 1'b1; tick(); fd2 = 1'b0;
    chk("fr_fc1", 32'(fc2), 1);
    ticks(4);
    chk("fr_m4_sv", 32'(sv2), 0);
    tick();
    chk("fr_m5_sv", 32'(sv2), 1);
    en2 = 1'b0; tick();
    fd2 = 1'b1; tick(); fd2 = 1'b0;
    chk("fr_fc2", 32'(fc2), 2);
    ticks(10);
    chk("fr_off_busy", 32'(busy2), 0);
    chk("fr_off_sv", 32'(sv2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
